// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder sequencer: state encoding and
// the bit-index width helper.
package serial_adder_pkg;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_PHASE_A = 2'd1;
   localparam logic [1:0] S_PHASE_B = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   // Bit-index width: enough to address WIDTH bits, never narrower than one bit
   function automatic int idx_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/serial_adder_ctrl_half_adder.sv
// Single-bit half adder, the datapath shared by the serial adder sequencer.
module Half_adder (
   input  logic bit1_i,
   input  logic bit2_i,
   output logic sum_o,
   output logic carry_o
);

   assign sum_o   = bit1_i ^ bit2_i;
   assign carry_o = bit1_i & bit2_i;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder. One half adder is time-shared: phase A adds the
// operand bits, phase B folds in the running carry. LSB first, two cycles per
// bit, result reported with a one-cycle done pulse.
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             ready_o,
   output logic             busy_o,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_o,
   output logic             done_o
);

   localparam int              IDX_W    = idx_width(WIDTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [IDX_W-1:0] r_idx;
   logic             r_run_carry;
   logic             r_s1;
   logic             r_c1;
   logic [WIDTH-1:0] r_work_sum;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;

   logic [WIDTH-1:0] w_bit_sel;
   logic             w_ha_in1;
   logic             w_ha_in2;
   logic             w_ha_sum;
   logic             w_ha_carry;
   logic [WIDTH-1:0] w_work_next;
   logic             w_carry_next;

   // One-hot mask of the bit currently being processed
   assign w_bit_sel = WIDTH'(1) << r_idx;

   // Half adder operand mux: operand bits in phase A, partial sum + carry in phase B
   always_comb begin
      w_ha_in1 = 1'b0;
      w_ha_in2 = 1'b0;
      case (r_state)
         S_PHASE_A: begin
            w_ha_in1 = |(r_a & w_bit_sel);
            w_ha_in2 = |(r_b & w_bit_sel);
         end
         S_PHASE_B: begin
            w_ha_in1 = r_s1;
            w_ha_in2 = r_run_carry;
         end
         default: begin
            w_ha_in1 = 1'b0;
            w_ha_in2 = 1'b0;
         end
      endcase
   end

   Half_adder u_ha (
      .bit1_i  (w_ha_in1),
      .bit2_i  (w_ha_in2),
      .sum_o   (w_ha_sum),
      .carry_o (w_ha_carry)
   );

   // Working sum with this cycle's result bit merged in, and the carry into the next bit
   assign w_work_next  = (r_work_sum & ~w_bit_sel) | ({WIDTH{w_ha_sum}} & w_bit_sel);
   assign w_carry_next = r_c1 | w_ha_carry;

   // Sequencer and working registers; sum/carry outputs update only on entry to DONE
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state     <= S_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_idx       <= '0;
         r_run_carry <= 1'b0;
         r_s1        <= 1'b0;
         r_c1        <= 1'b0;
         r_work_sum  <= '0;
         r_sum       <= '0;
         r_carry     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (valid_i) begin
                  r_a         <= a_i;
                  r_b         <= b_i;
                  r_idx       <= '0;
                  r_run_carry <= 1'b0;
                  r_work_sum  <= '0;
                  r_state     <= S_PHASE_A;
               end
            end
            S_PHASE_A: begin
               r_s1    <= w_ha_sum;
               r_c1    <= w_ha_carry;
               r_state <= S_PHASE_B;
            end
            S_PHASE_B: begin
               r_work_sum  <= w_work_next;
               r_run_carry <= w_carry_next;
               if (r_idx == LAST_IDX) begin
                  r_sum   <= w_work_next;
                  r_carry <= w_carry_next;
                  r_state <= S_DONE;
               end else begin
                  r_idx   <= r_idx + IDX_W'(1);
                  r_state <= S_PHASE_A;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign ready_o = (r_state == S_IDLE);
   assign busy_o  = (r_state != S_IDLE);
   assign done_o  = (r_state == S_DONE);
   assign sum_o   = r_sum;
   assign carry_o = r_carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: an 8-bit instance checked every
// cycle against a countdown/arithmetic model, plus a 1-bit instance.
module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         valid_i = 1'b0;
   logic [W-1:0] a_i = '0;
   logic [W-1:0] b_i = '0;
   logic         ready_o, busy_o, carry_o, done_o;
   logic [W-1:0] sum_o;

   logic         v1 = 1'b0;
   logic [0:0]   a1 = '0;
   logic [0:0]   b1 = '0;
   logic         ready1, busy1, carry1, done1;
   logic [0:0]   sum1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .a_i(a_i), .b_i(b_i),
      .ready_o(ready_o), .busy_o(busy_o), .sum_o(sum_o), .carry_o(carry_o), .done_o(done_o)
   );

   serial_adder_ctrl #(.WIDTH(1)) dut1 (
      .clk_i(clk), .rst_n_i(rst_n), .valid_i(v1), .a_i(a1), .b_i(b1),
      .ready_o(ready1), .busy_o(busy1), .sum_o(sum1), .carry_o(carry1), .done_o(done1)
   );

   // Model: m_cnt = cycles remaining until back in idle (0 = idle, 1 = done cycle)
   int           m_cnt;
   logic [W:0]   m_pend;
   logic [W:0]   m_res;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt  <= 0;
         m_pend <= '0;
         m_res  <= '0;
      end else if (m_cnt == 0) begin
         if (valid_i) begin
            m_cnt  <= 2 * W + 1;
            m_pend <= {1'b0, a_i} + {1'b0, b_i};
         end
      end else begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 2) m_res <= m_pend;
      end
   end

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (done_o) done_cnt <= done_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Per-cycle comparison of the 8-bit DUT against the model
   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            chk("ready", {31'd0, ready_o}, {31'd0, m_cnt == 0});
            chk("busy",  {31'd0, busy_o},  {31'd0, m_cnt != 0});
            chk("done",  {31'd0, done_o},  {31'd0, m_cnt == 1});
            chk("sum",   {24'd0, sum_o},   {24'd0, m_res[W-1:0]});
            chk("carry", {31'd0, carry_o}, {31'd0, m_res[W]});
         end
      end
   end

   // Present operands, wait for accept, then count edges until done_o
   task automatic add8(input logic [W-1:0] a, input logic [W-1:0] b, input bit keep,
                       output int lat, output int done_cyc);
      bit got;
      bit r;
      got = 1'b0;
      @(posedge clk); #1;
      a_i = a; b_i = b; valid_i = 1'b1;
      for (int k = 0; k < 100 && !got; k++) begin
         @(negedge clk); r = ready_o;
         @(posedge clk); got = r;
      end
      if (!got) chk("accept_timeout", 32'd0, 32'd1);
      #1;
      if (!keep) valid_i = 1'b0;
      lat = 0; got = 1'b0; done_cyc = 0;
      for (int k = 0; k < 100 && !got; k++) begin
         @(posedge clk); lat++;
         @(negedge clk); got = done_o;
      end
      done_cyc = cyc;
      if (!got) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic add1(input logic a, input logic b);
      bit got;
      bit r;
      int lat;
      got = 1'b0;
      @(posedge clk); #1;
      a1 = a; b1 = b; v1 = 1'b1;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk); r = ready1;
         @(posedge clk); got = r;
      end
      if (!got) chk("w1_accept_timeout", 32'd0, 32'd1);
      #1; v1 = 1'b0;
      lat = 0; got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(posedge clk); lat++;
         @(negedge clk); got = done1;
      end
      chk("w1_latency", lat, 32'd2);
      chk("w1_result", {30'd0, carry1, sum1}, {30'd0, 2'({1'b0, a} + {1'b0, b})});
   endtask

   initial begin
      int lat, d1, d2, dc0;
      logic [W-1:0] ra, rb;

      // Reset values of both instances
      #12;
      chk("rst_ready", {31'd0, ready_o}, 32'd1);
      chk("rst_busy",  {31'd0, busy_o},  32'd0);
      chk("rst_done",  {31'd0, done_o},  32'd0);
      chk("rst_sum",   {24'd0, sum_o},   32'd0);
      chk("rst_carry", {31'd0, carry_o}, 32'd0);
      chk("rst_w1",    {28'd0, ready1, busy1, done1, carry1}, 32'b1000);
      @(negedge clk); rst_n = 1'b1;
      cmp_en = 1'b1;

      // 0 + 0
      add8(8'h00, 8'h00, 1'b0, lat, d1);
      chk("lat_00", lat, 32'd16);
      chk("res_00", {23'd0, carry_o, sum_o}, 32'h000);

      // Carry ripples through every bit
      add8(8'hFF, 8'h01, 1'b0, lat, d1);
      chk("res_ff01", {23'd0, carry_o, sum_o}, 32'h100);

      // Back-to-back with valid held high
      add8(8'hA5, 8'h5A, 1'b1, lat, d1);
      chk("res_a55a", {23'd0, carry_o, sum_o}, 32'h0FF);
      add8(8'h80, 8'h80, 1'b0, lat, d2);
      chk("res_8080", {23'd0, carry_o, sum_o}, 32'h100);
      chk("b2b_spacing", d2 - d1, 32'd18);

      // Operand changes and valid pulses while busy are ignored
      @(posedge clk); #1;
      dc0 = done_cnt;
      a_i = 8'h3C; b_i = 8'h0F; valid_i = 1'b1;
      @(negedge clk);
      chk("ready_before_3c", {31'd0, ready_o}, 32'd1);
      @(posedge clk); #1;
      for (int k = 0; k < 15; k++) begin
         a_i = W'($urandom); b_i = W'($urandom); valid_i = 1'($urandom);
         @(posedge clk); #1;
      end
      valid_i = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("res_3c0f", {23'd0, carry_o, sum_o}, 32'h04B);
      chk("one_done", done_cnt - dc0, 32'd1);

      // Asynchronous reset mid-operation
      @(posedge clk); #1;
      a_i = 8'h7F; b_i = 8'h7F; valid_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      dc0 = done_cnt;
      repeat (5) @(posedge clk);
      #2; rst_n = 1'b0; #1;
      chk("arst_ready", {31'd0, ready_o}, 32'd1);
      chk("arst_busy",  {31'd0, busy_o},  32'd0);
      chk("arst_done",  {31'd0, done_o},  32'd0);
      chk("arst_res",   {23'd0, carry_o, sum_o}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("arst_no_done", done_cnt - dc0, 32'd0);
      chk("arst_idle", {31'd0, ready_o}, 32'd1);
      add8(8'h01, 8'h02, 1'b0, lat, d1);
      chk("res_0102", {23'd0, carry_o, sum_o}, 32'h003);

      // Random operands with random idle gaps
      for (int n = 0; n < 25; n++) begin
         ra = W'($urandom); rb = W'($urandom);
         add8(ra, rb, 1'b0, lat, d1);
         chk("lat_rand", lat, 32'd16);
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      // One-bit instance: every operand combination
      add1(1'b1, 1'b1);
      add1(1'b0, 1'b0);
      add1(1'b1, 1'b0);
      add1(1'b0, 1'b1);

      repeat (3) @(posedge clk);
      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial N-bit adder controller that time-shares one Half_adder instance to add two WIDTH-bit operands, LSB first. Each bit is computed in two cycles: phase A adds the operand bits, phase B adds the partial sum to the running carry. Operands enter through a valid/ready handshake; the result is reported with a one-cycle done pulse. The block is the sequencer for the existing half-adder datapath and is the first multi-bit arithmetic block built on it.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 1..32)

Ports:
clk_i  input  1  system clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
valid_i  input  1  operand request; accepted when valid_i && ready_o at a rising edge
a_i  input  WIDTH  operand A, sampled on accept
b_i  input  WIDTH  operand B, sampled on accept
ready_o  output  1  high only in IDLE
busy_o  output  1  high in PHASE_A, PHASE_B and DONE
sum_o  output  WIDTH  registered result of the last completed addition
carry_o  output  1  registered carry-out of MSB for the last completed addition
done_o  output  1  one-cycle pulse, result valid

Behaviour:
- Interface fixed: single clock clk_i; reset rst_n_i is asynchronous and active-low.
- Reset values: state IDLE, ready_o=1, busy_o=0, done_o=0, sum_o=0, carry_o=0. Internal operand registers, bit index, running carry, s1/c1 holding registers and working sum are all cleared.
- States: IDLE, PHASE_A, PHASE_B, DONE.
- IDLE: on valid_i && ready_o, latch a_i and b_i, clear idx, run_carry and work_sum, then go to PHASE_A. Otherwise stay in IDLE.
- PHASE_A: Half_adder inputs are a_q[idx] and b_q[idx]. Register s1 <= ha_sum and c1 <= ha_carry. Go to PHASE_B.
- PHASE_B: Half_adder inputs are s1 and run_carry. work_sum[idx] <= ha_sum and run_carry <= c1 | ha_carry.
  - If idx == WIDTH-1: load sum_o with the completed work_sum (including the bit written this cycle), load carry_o with the new carry, and go to DONE.
  - Otherwise: idx <= idx+1 and go to PHASE_A.
- DONE: done_o=1 for exactly this cycle, then go to IDLE unconditionally.
- Half_adder input mux is combinational, selected by state. In IDLE and DONE its inputs are 0.
- Latency: if accept happens at edge E0, done_o is high in the cycle after edge E0+2*WIDTH. ready_o returns high one cycle later.
- Throughput: one addition per 2*WIDTH+2 cycles with valid_i held continuously.
- sum_o and carry_o hold the previous result for the whole computation and change only on the edge entering DONE.
- valid_i while ready_o=0 is ignored. There is no queueing and no error flag.
- Changes on a_i/b_i after accept have no effect.
- Arithmetic: {carry_o, sum_o} = a + b, modulo 2^(WIDTH+1), unsigned.
- WIDTH=1: PHASE_A, PHASE_B, DONE only; done_o arrives 2 cycles after the accept edge.
- Reset asserted mid-operation: immediate abort to the reset values, no done_o. The computation is not resumed after release.
- idx width is $clog2(WIDTH), minimum 1. idx never exceeds WIDTH-1.

Decomposition:
- Shared package serial_adder_pkg holds:
  - state encoding localparams: S_IDLE=2'd0, S_PHASE_A=2'd1, S_PHASE_B=2'd2, S_DONE=2'd3
  - index-width helper constant/function
- Sub-module: one instance of the existing Half_adder (bit1_i, bit2_i, sum_o, carry_o). There is no second adder instance; sharing the single instance is the point of the block.

Test Plan:
- Reset, then a=0x00, b=0x00 with WIDTH=8 -> ready_o drops after the accept edge; done_o pulses 16 edges after accept; sum_o=0x00, carry_o=0.
- a=0xFF, b=0x01 -> sum_o=0x00, carry_o=1. Carry ripples through all 8 bits; sum_o keeps its old value until the DONE edge.
- a=0xA5, b=0x5A, then a=0x80, b=0x80 back-to-back with valid_i held high -> first result 0xFF/c=0, second result 0x00/c=1. The second accept occurs only in the IDLE cycle after done_o; the two done pulses are 18 cycles apart.
- Start a=0x3C, b=0x0F, then toggle a_i/b_i to random values and pulse valid_i during busy -> result is 0x4B/c=0 and exactly one done_o.
- Start a=0x7F, b=0x7F, then drop rst_n_i 5 cycles after accept -> all outputs are 0 asynchronously; no done_o; ready_o=1 after release. A new add of 0x01+0x02 gives 0x03.
- WIDTH=1 build: a=1, b=1 -> sum_o=0, carry_o=1, done_o 2 edges after accept.
